// File: rtl/axi_time_trigger_sched.sv
// ============================================================================
//  Module      : axi_time_trigger_sched
//  Description : Round-robin arbiter sharing the timed RX-trigger port of the
//                axi_time counter core among NUM_REQ timestamp requesters.
//                Optional late-timestamp rejection is compiled in by defining
//                AXI_TIME_TRIG_SCHED_LATE_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_time_trigger_sched #(
    parameter int NUM_REQ      = 4,
    parameter int COUNT_WIDTH  = 64,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                           time_clk,
    input  logic                           time_resetn,
    input  logic                           time_running,
    input  logic [COUNT_WIDTH-1:0]         time_counter,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_late,
    output logic [COUNT_WIDTH-1:0]         time_rx_trigger,
    output logic                           time_rx_trigger_valid,
    input  logic                           time_rx_trigger_ready,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDW-1:0]          r_rr_ptr;
    logic [IDW-1:0]          r_grant_id;
    logic [COUNT_WIDTH-1:0]  r_ts;
    logic                    r_valid;
    logic                    r_busy;

    logic                    w_found;
    logic [IDW-1:0]          w_winner;
    logic [IDW:0]            w_sum;
    logic [IDW:0]            w_ptr_sum;
    logic [IDW-1:0]          w_ptr_next;
    logic [COUNT_WIDTH-1:0]  w_win_data;
    logic                    w_accept;
    logic                    w_late;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDW-1:0];
            end
        end
    end

    // Pointer after the winner (mod NUM_REQ) and the winner's timestamp.
    always_comb begin
        w_ptr_sum  = {1'b0, w_winner} + (IDW+1)'(1);
        w_ptr_next = (w_ptr_sum == (IDW+1)'(NUM_REQ)) ? '0 : w_ptr_sum[IDW-1:0];
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_win_data = req_data[i*COUNT_WIDTH +: COUNT_WIDTH];
            end
        end
    end

`ifdef AXI_TIME_TRIG_SCHED_LATE_CHECK_EN
    // Deadline is one bit wider than the counter so a sum past the maximum
    // counter value cannot wrap and make a stale timestamp look early.
    logic [COUNT_WIDTH:0]    w_deadline;
    logic [NUM_REQ-1:0]      r_late;

    assign w_deadline = {1'b0, time_counter} + (COUNT_WIDTH+1)'(GUARD_CYCLES);
    assign w_late     = ({1'b0, r_ts} < w_deadline);

    // Late flag pulses for one cycle on the owner's lane when CHECK drops it.
    always_ff @(posedge time_clk) begin
        if (!time_resetn) begin
            r_late <= '0;
        end else if (r_state == ST_CHECK && w_late) begin
            r_late <= NUM_REQ'(1) << r_grant_id;
        end else begin
            r_late <= '0;
        end
    end

    assign req_late = r_late;
`else
    logic w_unused_counter;

    assign w_unused_counter = ^{time_counter, GUARD_CYCLES[0]};
    assign w_late           = 1'b0;
    assign req_late         = '0;
`endif

    // FSM state register.
    always_ff @(posedge time_clk) begin
        if (!time_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and the combinational requester handshake.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        req_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (time_running && w_found) begin
                    w_accept     = 1'b1;
                    req_ready    = NUM_REQ'(1) << w_winner;
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_next_state = w_late ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (time_rx_trigger_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered datapath: captured timestamp, grant bookkeeping, outputs.
    always_ff @(posedge time_clk) begin
        if (!time_resetn) begin
            r_ts       <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ts       <= w_win_data;
                r_grant_id <= w_winner;
                r_rr_ptr   <= w_ptr_next;
            end
            r_valid <= (w_next_state == ST_ISSUE);
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    assign time_rx_trigger       = r_ts;
    assign time_rx_trigger_valid = r_valid;
    assign grant_id              = r_grant_id;
    assign busy                  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_axi_time_trigger_sched.sv
// ============================================================================
//  Module      : tb_axi_time_trigger_sched
//  Description : Self-checking bench for axi_time_trigger_sched: a table of
//                single-request cases, directed multi-cycle sequences and a
//                randomized run against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_time_trigger_sched;

    localparam int N = 4;
    localparam int W = 64;
    localparam int G = 4;
`ifdef AXI_TIME_TRIG_SCHED_LATE_CHECK_EN
    localparam bit LATE_EN = 1'b1;
`else
    localparam bit LATE_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           running = 1'b0;
    logic [W-1:0]   counter = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_late;
    logic [W-1:0]   trig;
    logic           trig_valid;
    logic           core_ready = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    axi_time_trigger_sched #(.NUM_REQ(N), .COUNT_WIDTH(W), .GUARD_CYCLES(G)) dut (
        .time_clk              (clk),
        .time_resetn           (resetn),
        .time_running          (running),
        .time_counter          (counter),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_data              (req_data),
        .req_late              (req_late),
        .time_rx_trigger       (trig),
        .time_rx_trigger_valid (trig_valid),
        .time_rx_trigger_ready (core_ready),
        .grant_id              (grant_id),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] one = 1;
        return one << idx;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; running = 1'b0; req_valid = '0; core_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit           m_hold;   // a timestamp is owned by the scheduler
    bit           m_iss;    // it passed the timing check and is being offered
    logic [W-1:0] m_ts;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] m_late;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_iss = 0; m_ts = '0; m_owner = 0; m_ptr = 0; m_late = '0;
    endtask

    task automatic model_edge();
        int  p;
        bit  late;
        if (!m_hold) begin
            m_late = '0;
            p = rr_pick(m_ptr, req_valid);
            if (running && p >= 0) begin
                m_ts    = req_data[p*W +: W];
                m_owner = p;
                m_ptr   = (p + 1) % N;
                m_hold  = 1;
                m_iss   = 0;
            end
        end else if (!m_iss) begin
            late = LATE_EN && ({1'b0, m_ts} < ({1'b0, counter} + 65'(G)));
            if (late) begin
                m_late = onehot(m_owner);
                m_hold = 0;
            end else begin
                m_iss = 1;
            end
        end else begin
            m_late = '0;
            if (core_ready) m_hold = 0;
        end
    endtask

    // ---------------- table of single-request cases ----------------
    typedef struct {
        int           req;
        logic [W-1:0] ts;
        logic [W-1:0] cnt;
        bit           late;   // expected verdict when late checking is built in
    } vec_t;

    vec_t tbl[6];

    task automatic run_one(input vec_t v);
        bit drop;
        drop = v.late && LATE_EN;
        @(negedge clk);
        running = 1'b1; core_ready = 1'b1; counter = v.cnt;
        req_data[v.req*W +: W] = v.ts;
        req_valid = onehot(v.req);
        #1 chk("tbl_ready", W'(req_ready), W'(onehot(v.req)));
        @(negedge clk);
        req_valid = '0;
        chk("tbl_check_busy", W'(busy), 1);
        chk("tbl_grant_id", W'(grant_id), W'(v.req));
        chk("tbl_check_valid", W'(trig_valid), 0);
        @(negedge clk);
        if (drop) begin
            chk("tbl_late", W'(req_late), W'(onehot(v.req)));
            chk("tbl_drop_valid", W'(trig_valid), 0);
            chk("tbl_drop_busy", W'(busy), 0);
        end else begin
            chk("tbl_issue_valid", W'(trig_valid), 1);
            chk("tbl_issue_data", trig, v.ts);
            chk("tbl_issue_late", W'(req_late), 0);
        end
        @(negedge clk);
        chk("tbl_after_valid", W'(trig_valid), 0);
        chk("tbl_after_late", W'(req_late), 0);
        chk("tbl_after_busy", W'(busy), 0);
    endtask

    initial begin
        int got[$];
        int issued;
        logic [W-1:0] rr_ts[N];

        tbl[0] = '{req: 0, ts: 64'd1000, cnt: 64'd100, late: 1'b0};
        tbl[1] = '{req: 2, ts: 64'd105,  cnt: 64'd102, late: 1'b1};
        tbl[2] = '{req: 1, ts: 64'd106,  cnt: 64'd102, late: 1'b0};
        tbl[3] = '{req: 3, ts: 64'd0,    cnt: 64'hFFFF_FFFF_FFFF_FFFE, late: 1'b1};
        tbl[4] = '{req: 0, ts: 64'hFFFF_FFFF_FFFF_FFFF, cnt: 64'hFFFF_FFFF_FFFF_FFFC, late: 1'b1};
        tbl[5] = '{req: 1, ts: 64'hFFFF_FFFF_FFFF_FFFF, cnt: 64'hFFFF_FFFF_FFFF_FFFB, late: 1'b0};

        // Reset state.
        do_reset();
        #1;
        chk("rst_trig", trig, 0);
        chk("rst_valid", W'(trig_valid), 0);
        chk("rst_grant", W'(grant_id), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_late", W'(req_late), 0);
        chk("rst_ready", W'(req_ready), 0);

        for (int i = 0; i < 6; i++) run_one(tbl[i]);

        // Round-robin with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            rr_ts[i] = 64'd10000 + 64'(i * 111);
            req_data[i*W +: W] = rr_ts[i];
        end
        counter = '0; core_ready = 1'b1; running = 1'b1; req_valid = '1;
        issued = 0;
        for (int c = 0; c < 30 && got.size() < 5; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) got.push_back(i);
            if (trig_valid && issued < got.size()) begin
                chk("rr_data", trig, rr_ts[got[issued]]);
                issued++;
            end
            @(negedge clk);
        end
        chk("rr_grant_count", W'(got.size()), 5);
        for (int k = 0; k < got.size() && k < 5; k++) chk("rr_order", W'(got[k]), W'(k % N));

        // Backpressure: core not ready for 10 cycles, running drops midway.
        do_reset();
        req_data[1*W +: W] = 64'd5000; counter = '0; running = 1'b1; req_valid = 4'b0010;
        #1 chk("bp_ready", W'(req_ready), W'(4'b0010));
        @(negedge clk);
        req_valid = 4'b0011;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 5) running = 1'b0;
            #1;
            chk("bp_valid", W'(trig_valid), 1);
            chk("bp_data", trig, 64'd5000);
            chk("bp_ready_low", W'(req_ready), 0);
            chk("bp_busy", W'(busy), 1);
        end
        core_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", W'(trig_valid), 0);
        chk("bp_done_busy", W'(busy), 0);

        // Counter stopped: request waits, then is granted in the same cycle.
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stop_ready", W'(req_ready), 0);
            chk("stop_busy", W'(busy), 0);
            @(negedge clk);
        end
        running = 1'b1;
        #1 chk("run_ready", W'(req_ready), W'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset while issuing; next grant must restart from index 0.
        do_reset();
        running = 1'b1; core_ready = 1'b0; req_data[1*W +: W] = 64'd7000; req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("rsti_valid_before", W'(trig_valid), 1);
        resetn = 1'b0; req_valid = 4'b1001;
        @(negedge clk);
        chk("rsti_valid", W'(trig_valid), 0);
        chk("rsti_trig", trig, 0);
        chk("rsti_grant", W'(grant_id), 0);
        chk("rsti_busy", W'(busy), 0);
        chk("rsti_late", W'(req_late), 0);
        resetn = 1'b1;
        #1 chk("rsti_next_grant", W'(req_ready), W'(4'b0001));

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        counter = 64'd1000;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            chk("rnd_valid", W'(trig_valid), W'(m_hold && m_iss));
            chk("rnd_trig", trig, m_ts);
            chk("rnd_grant", W'(grant_id), W'(m_owner));
            chk("rnd_late", W'(req_late), W'(m_late));
            chk("rnd_busy", W'(busy), W'(m_hold));
            running    = ($urandom_range(0, 9) != 0);
            core_ready = ($urandom_range(0, 3) != 0);
            req_valid  = N'($urandom);
            counter    = counter + 1;
            for (int i = 0; i < N; i++) begin
                req_data[i*W +: W] = counter + 64'($urandom_range(0, 10)) - 64'd3;
            end
            #1;
            begin
                int p;
                logic [N-1:0] exp_ready;
                p = rr_pick(m_ptr, req_valid);
                exp_ready = (!m_hold && running && p >= 0) ? onehot(p) : '0;
                chk("rnd_ready", W'(req_ready), W'(exp_ready));
            end
            @(posedge clk);
            model_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
